// File: rtl/nano_pkg.sv
// nano_pkg: shared opcodes, ALU ops, sequencer states and the strobe bundle
package nano_pkg;
    localparam int OPC_W = 8;
    localparam int DATA_W = 8;
    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 8'h00, OP_LDA = 8'h01, OP_STA = 8'h02, OP_ADD = 8'h03, OP_SUB = 8'h04,
        OP_AND = 8'h05, OP_JMP = 8'h06, OP_JZ = 8'h07, OP_JC = 8'h08, OP_HLT = 8'h0F
    } opcode_t;
    typedef enum logic [2:0] {ALU_PASS = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3} alu_op_t;
    typedef enum logic [2:0] {S_FETCH1, S_FETCH2, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
    typedef struct packed {
        logic    inc_pc;
        logic    load_pc;
        logic    addr_sel;
        logic    mem_we;
        logic    load_acc;
        alu_op_t alu_op;
        logic    halted;
        logic    illegal;
    } strobe_t;
    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND};
    endfunction
endpackage

// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: sequencer <-> datapath/memory control bundle
interface ctrl_seq_if import nano_pkg::*; ();
    logic              run;
    logic [DATA_W-1:0] mem_rdata;
    logic              z_flag;
    logic              c_flag;
    logic              inc_PC;
    logic              load_PC;
    logic [DATA_W-1:0] pc_target;
    logic              addr_sel;
    logic              mem_we;
    logic              load_ACC;
    alu_op_t           alu_op;
    logic              halted;
    logic              illegal;
    modport master (
        input  run, mem_rdata, z_flag, c_flag,
        output inc_PC, load_PC, pc_target, addr_sel, mem_we, load_ACC, alu_op, halted, illegal
    );
    modport slave (
        output run, mem_rdata, z_flag, c_flag,
        input  inc_PC, load_PC, pc_target, addr_sel, mem_we, load_ACC, alu_op, halted, illegal
    );
endinterface

// File: rtl/ctrl_seq_decode.sv
// ctrl_decode: state + IR + flags -> strobe bundle (pure combinational)
module ctrl_decode import nano_pkg::*; (
    input  state_t           state,
    input  logic [OPC_W-1:0] ir,
    input  logic             run,
    input  logic             z_flag,
    input  logic             c_flag,
    output strobe_t          strb
);
    logic exec, alu, legal, taken;
    always_comb begin
        exec = state == S_EXEC;
        alu = is_alu(ir);
        legal = alu || ir inside {OP_NOP, OP_STA, OP_JMP, OP_JZ, OP_JC, OP_HLT};
        taken = ir == OP_JMP || (ir == OP_JZ && z_flag) || (ir == OP_JC && c_flag);
        strb = '0;
        strb.inc_pc = (state == S_FETCH1 && run) || state == S_FETCH2;
        strb.load_pc = exec && taken;
        strb.addr_sel = exec && (alu || ir == OP_STA);
        strb.mem_we = exec && ir == OP_STA;
        strb.load_acc = state == S_WB;
        strb.alu_op = state != S_WB ? ALU_PASS : ir == OP_ADD ? ALU_ADD :
                      ir == OP_SUB ? ALU_SUB : ir == OP_AND ? ALU_AND : ALU_PASS;
        strb.halted = state == S_HALT;
        strb.illegal = exec && !legal;
    end
endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: fetch/decode/execute sequencer holding IR and ARG, driving PC/memory/ACC strobes
module ctrl_seq import nano_pkg::*; (
    input logic        clk,
    input logic        reset,
    ctrl_seq_if.master bus
);
    state_t            state_q, state_d;
    logic [OPC_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0] arg_q, arg_d;
    strobe_t           strb;
    ctrl_decode u_decode (
        .state  (state_q),
        .ir     (ir_q),
        .run    (bus.run),
        .z_flag (bus.z_flag),
        .c_flag (bus.c_flag),
        .strb   (strb)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH1;
            ir_q <= '0;
            arg_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
            arg_q <= arg_d;
        end
    end
    always_comb begin
        ir_d = state_q == S_FETCH2 ? bus.mem_rdata : ir_q;
        arg_d = state_q == S_DECODE ? bus.mem_rdata : arg_q;
        case (state_q)
            S_FETCH1: state_d = bus.run ? S_FETCH2 : S_FETCH1;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = is_alu(ir_q) ? S_WB : ir_q == OP_HLT ? S_HALT : S_FETCH1;
            S_WB:     state_d = S_FETCH1;
            default:  state_d = state_q == S_HALT ? S_HALT : S_FETCH1;
        endcase
    end
    // reset silences every output, even a pending fetch strobe with run=1
    always_comb begin
        bus.inc_PC = !reset && strb.inc_pc;
        bus.load_PC = !reset && strb.load_pc;
        bus.addr_sel = !reset && strb.addr_sel;
        bus.mem_we = !reset && strb.mem_we;
        bus.load_ACC = !reset && strb.load_acc;
        bus.alu_op = reset ? ALU_PASS : strb.alu_op;
        bus.halted = !reset && strb.halted;
        bus.illegal = !reset && strb.illegal;
        bus.pc_target = reset ? '0 : arg_q;
    end
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed + random programs checked against an instruction-level model
module tb_ctrl_seq;
    import nano_pkg::*;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    ctrl_seq_if bus ();
    ctrl_seq dut (.clk(clk), .reset(reset), .bus(bus.master));
    logic [7:0] mem [256];
    logic [7:0] mm [256];
    logic [7:0] pc, acc, mpc, macc, acc_keep;
    logic carry, mc;
    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask
    function automatic logic [9:0] obs();
        return {bus.inc_PC, bus.load_PC, bus.addr_sel, bus.mem_we, bus.load_ACC,
                bus.alu_op, bus.halted, bus.illegal};
    endfunction
    // environment: PC register, registered memory, accumulator with flags
    task automatic tick();
        logic [7:0] a, rd, tgt;
        logic inc, ld, we, la;
        alu_op_t op;
        a = bus.addr_sel ? bus.pc_target : pc;
        rd = bus.mem_rdata;
        tgt = bus.pc_target;
        {inc, ld, we, la, op} = {bus.inc_PC, bus.load_PC, bus.mem_we, bus.load_ACC, bus.alu_op};
        @(posedge clk);
        #1;
        bus.mem_rdata = mem[a];
        if (we) mem[tgt] = acc;
        if (inc) pc = pc + 8'd1;
        else if (ld) pc = tgt;
        if (la)
            case (op)
                ALU_ADD: {carry, acc} = {1'b0, acc} + {1'b0, rd};
                ALU_SUB: {carry, acc} = {1'b0, acc} - {1'b0, rd};
                ALU_AND: acc = acc & rd;
                default: acc = rd;
            endcase
        bus.z_flag = acc == 8'd0;
        bus.c_flag = carry;
        #1;
    endtask
    task automatic set_acc(input logic [7:0] v, input logic c);
        acc = v; macc = v; carry = c; mc = c;
        bus.z_flag = v == 8'd0;
        bus.c_flag = c;
    endtask
    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.run = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1 chk("rst_out", obs(), 0);
            tick();
        end
        reset = 1'b0;
        pc = 8'd0;
        mpc = 8'd0;
        #1 chk("rst_arg", bus.pc_target, 0);
    endtask
    // runs one instruction from S_FETCH1; expectations come from the ISA timing table
    task automatic run_instr(input int pause, output bit hlt);
        logic [7:0] op, arg, m;
        logic [2:0] ao;
        logic [9:0] e;
        bit alu, sta, legal, taken;
        int n;
        op = mm[mpc];
        arg = mm[mpc + 8'd1];
        bus.run = 1'b0;
        for (int i = 0; i < pause; i++) begin
            #1 chk("pause", obs(), 0);
            tick();
        end
        bus.run = 1'b1;
        alu = op inside {8'h01, 8'h03, 8'h04, 8'h05};
        sta = op == 8'h02;
        legal = alu || sta || op inside {8'h00, 8'h06, 8'h07, 8'h08, 8'h0F};
        taken = op == 8'h06 || (op == 8'h07 && macc == 8'd0) || (op == 8'h08 && mc);
        ao = op == 8'h03 ? 3'd1 : op == 8'h04 ? 3'd2 : op == 8'h05 ? 3'd3 : 3'd0;
        n = alu ? 5 : 4;
        for (int k = 0; k < n; k++) begin
            e = {k < 2, k == 3 && taken, k == 3 && (alu || sta), k == 3 && sta, k == 4,
                 k == 4 ? ao : 3'd0, 1'b0, k == 3 && !legal};
            #1 chk($sformatf("op%02h_c%0d", op, k), obs(), e);
            if (k == 3) chk("pc_target", bus.pc_target, arg);
            tick();
            if (k < n - 1) bus.run = 1'($urandom_range(0, 1));
        end
        m = mm[arg];
        mpc = mpc + 8'd2;
        case (op)
            8'h01: macc = m;
            8'h02: mm[arg] = macc;
            8'h03: {mc, macc} = {1'b0, macc} + {1'b0, m};
            8'h04: {mc, macc} = {1'b0, macc} - {1'b0, m};
            8'h05: macc = macc & m;
            default: ;
        endcase
        if (taken) mpc = arg;
        hlt = op == 8'h0F;
        if (hlt)
            for (int i = 0; i < 20; i++) begin
                bus.run = 1'($urandom_range(0, 1));
                #1 chk("halt", obs(), 10'b0000000010);
                tick();
            end
        chk("pc", pc, mpc);
        chk("acc", acc, macc);
        if (sta) chk("sta_mem", mem[arg], mm[arg]);
    endtask
    bit h;
    initial begin
        bus.run = 1'b0;
        bus.mem_rdata = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        set_acc(8'd0, 1'b0);
        // reset with run held high, then first fetch strobe
        do_reset(2);
        #1 chk("first_inc", bus.inc_PC, 1);
        // LDA 0x10
        mem[0] = 8'h01; mem[1] = 8'h10; mem[8'h10] = 8'h5A;
        mm = mem;
        run_instr(0, h);
        chk("lda_acc", acc, 8'h5A);
        // JZ 0x40 taken then not taken
        mem[0] = 8'h07; mem[1] = 8'h40;
        mm = mem;
        do_reset(1);
        set_acc(8'h00, 1'b0);
        run_instr(0, h);
        chk("jz_taken_pc", pc, 8'h40);
        do_reset(1);
        set_acc(8'h05, 1'b0);
        run_instr(0, h);
        chk("jz_not_pc", pc, 8'h02);
        // STA 0x20
        mem[0] = 8'h02; mem[1] = 8'h20;
        mm = mem;
        do_reset(1);
        set_acc(8'hC3, 1'b1);
        run_instr(0, h);
        // illegal 0x0B followed by a NOP, then HLT
        mem[0] = 8'h0B; mem[1] = 8'h77; mem[2] = 8'h00; mem[3] = 8'h00; mem[4] = 8'h0F;
        mm = mem;
        do_reset(1);
        run_instr(0, h);
        run_instr(0, h);
        run_instr(0, h);
        chk("hlt_seen", 32'(h), 1);
        // paused fetch, then reset in S_WB abandons the load
        mem[0] = 8'h01; mem[1] = 8'h10;
        mm = mem;
        do_reset(1);
        set_acc(8'h11, 1'b0);
        run_instr(10, h);
        mpc = 8'd0;
        pc = 8'd0;
        acc_keep = acc;
        bus.run = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        #1 chk("rst_wb_out", obs(), 0);
        tick();
        reset = 1'b0;
        bus.run = 1'b0;
        #1 chk("rst_wb_idle", obs(), 0);
        chk("rst_wb_arg", bus.pc_target, 0);
        chk("rst_wb_acc", acc, acc_keep);
        bus.run = 1'b1;
        #1 chk("rst_wb_inc", bus.inc_PC, 1);
        // random programs
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = $urandom_range(0, 9) < 7 ? 8'($urandom_range(0, 8)) : 8'($urandom);
            mm = mem;
            do_reset(1);
            set_acc(8'($urandom), 1'($urandom_range(0, 1)));
            for (int j = 0; j < 150; j++) begin
                run_instr($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, h);
                if (h) break;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
